// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: default width, FSM states
// and step-counter width.
package mul_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int CNT_W     = $clog2(MUL_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple adder in the step datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/shift_add_step.sv
// One radix-2 shift-add step: sum = hi + (lo[0] ? mcand : 0) on a WIDTH-bit
// ripple of full adders, then {carry, sum, lo} shifted right by one.
module shift_add_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    assign addend   = lo_i[0] ? mcand_i : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a_i (hi_i[i]),
            .b_i (addend[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    // The carry-out becomes the new top bit of hi, so hi + mcand never wraps.
    assign hi_o = {carry[WIDTH], sum[WIDTH-1:1]};
    assign lo_o = {sum[0], lo_i[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, product = a * b in WIDTH cycles.
// Optional SHIFT_ADD_MULTIPLIER_ADDEND_EN adds an addend port: product = a*b + addend.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SHIFT_ADD_MULTIPLIER_ADDEND_EN
    input  logic [WIDTH-1:0]   addend,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    // Counter sized from the instance width so non-default WIDTH still fits.
    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   hi_init;

`ifdef SHIFT_ADD_MULTIPLIER_ADDEND_EN
    assign hi_init = addend;
`else
    assign hi_init = '0;
`endif

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .mcand_i (mcand_q),
        .hi_o    (step_hi),
        .lo_o    (step_lo)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Next-state: accept in IDLE, WIDTH shift-add steps in RUN, hold result in DONE.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    hi_d    = hi_init;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                // Last step: publish the full product straight from the datapath.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d   = {step_hi, step_lo};
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, results, backpressure, reset abort.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, addend;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SHIFT_ADD_MULTIPLIER_ADDEND_EN
        .addend    (addend),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one job; hold = cycles out_ready stays low after out_valid rises.
    task automatic do_job(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] tadd, input logic [31:0] exp,
                          input int hold);
        int  n;
        logic busy_ok;
        @(negedge clk);
        a = ta; b = tb_v; addend = tadd; in_valid = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; addend = ~tadd;
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 16);
        chk("in_ready_run", busy_ok, 1);
        chk("product", product, exp);
        chk("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'h1111 + 16'(i); b = 16'h0003;
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_product", product, exp);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_product_kept", product, exp);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; addend = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_job(16'd90,   16'd33,   16'd0, 32'd2970,       0);
        do_job(16'd901,  16'd300,  16'd0, 32'd270300,     0);
        do_job(16'hFFFF, 16'hFFFF, 16'd0, 32'hFFFE0001,   0);
        do_job(16'd0,    16'd1234, 16'd0, 32'd0,          0);
        do_job(16'd1234, 16'd0,    16'd0, 32'd0,          0);
        do_job(16'd255,  16'd257,  16'd0, 32'd65535,      5);

        // Abort mid-RUN: reset 7 cycles after acceptance.
        @(negedge clk);
        a = 16'd100; b = 16'd100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_job(16'd5, 16'd7, 16'd0, 32'd35, 0);

`ifdef SHIFT_ADD_MULTIPLIER_ADDEND_EN
        do_job(16'd2,    16'd33,   16'd24,   32'd90,        0);
        do_job(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000,  0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
